// File: rtl/branch_pkg.sv
// Shared types for the gshare predictor and its branch training tracker.
// Entry and training bundles are packed so they move as single buses.
package branch_pkg;

    localparam int HIST_W = 7;

    typedef struct packed {
        logic [HIST_W-1:0] pc;
        logic [HIST_W-1:0] history;
        logic              pred_taken;
    } bp_entry_t;

    typedef struct packed {
        logic              valid;
        logic              taken;
        logic              mispredicted;
        logic [HIST_W-1:0] history;
        logic [HIST_W-1:0] pc;
    } train_t;

    // History as it should have looked after the resolved branch shifted in.
    function automatic logic [HIST_W-1:0] repair_history(input logic [HIST_W-1:0] h,
                                                         input logic              taken);
        return {h[HIST_W-2:0], taken};
    endfunction

endpackage

// File: rtl/branch_train_tracker_if.sv
// Prediction/resolution/training signal bundle of the branch train tracker.
// The fetch side is the master, the tracker is the slave.
interface branch_train_tracker_if #(parameter int DEPTH = 8);
    import branch_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              pred_valid;
    logic [HIST_W-1:0] pred_pc;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_history;
    logic              pred_ready;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              train_valid;
    logic              train_taken;
    logic              train_mispredicted;
    logic [HIST_W-1:0] train_history;
    logic [HIST_W-1:0] train_pc;
    logic              restore_valid;
    logic [HIST_W-1:0] restore_history;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow;
    logic              underflow;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_history, resolve_valid, resolve_taken,
        input  pred_ready, train_valid, train_taken, train_mispredicted, train_history,
               train_pc, restore_valid, restore_history, occupancy, overflow, underflow
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_history, resolve_valid, resolve_taken,
        output pred_ready, train_valid, train_taken, train_mispredicted, train_history,
               train_pc, restore_valid, restore_history, occupancy, overflow, underflow
    );

endinterface

// File: rtl/bp_entry_fifo.sv
// Circular buffer of in-flight branch entries; head entry readable combinationally.
// Flush wins over push/pop and empties the buffer on the next cycle.
module bp_entry_fifo
    import branch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  bp_entry_t        wr_entry_i,
    output bp_entry_t        rd_entry_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o
);

    bp_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign rd_entry_o  = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OCC_W'(DEPTH));
    assign empty_o     = (occ_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so increment wraps on its own.
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            occ_d = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
    end

endmodule

// File: rtl/branch_train_tracker.sv
// Tracks issued predictions in order and emits registered training/restore pulses on resolve.
// Training lands 1 cycle after a pop; a mispredict flushes all younger (wrong-path) entries.
module branch_train_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                    clk,
    input logic                    areset,
    branch_train_tracker_if.slave  bus
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    bp_entry_t        wr_entry, rd_entry;
    logic [OCC_W-1:0] occ;
    logic             full, empty;
    logic             push_req, pop, mispred;

    train_t            train_q, train_d;
    logic              restore_vld_q, restore_vld_d;
    logic [HIST_W-1:0] restore_hist_q, restore_hist_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    assign wr_entry = '{pc: bus.pred_pc, history: bus.pred_history, pred_taken: bus.pred_taken};

    assign push_req = bus.pred_valid && !full;
    assign pop      = bus.resolve_valid && !empty;
    assign mispred  = pop && (rd_entry.pred_taken != bus.resolve_taken);

    // A push alongside a mispredict is wrong-path; the flush also discards it.
    bp_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .areset      (areset),
        .push_i      (push_req && !mispred),
        .pop_i       (pop),
        .flush_i     (mispred),
        .wr_entry_i  (wr_entry),
        .rd_entry_o  (rd_entry),
        .occupancy_o (occ),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        train_d        = '0;
        restore_vld_d  = 1'b0;
        restore_hist_d = '0;
        overflow_d     = overflow_q  || (bus.pred_valid && full);
        underflow_d    = underflow_q || (bus.resolve_valid && empty);
        if (pop) begin
            train_d.valid        = 1'b1;
            train_d.taken        = bus.resolve_taken;
            train_d.mispredicted = mispred;
            train_d.history      = rd_entry.history;
            train_d.pc           = rd_entry.pc;
        end
        if (mispred) begin
            restore_vld_d  = 1'b1;
            restore_hist_d = repair_history(rd_entry.history, bus.resolve_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            train_q        <= '0;
            restore_vld_q  <= 1'b0;
            restore_hist_q <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            train_q        <= train_d;
            restore_vld_q  <= restore_vld_d;
            restore_hist_q <= restore_hist_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.pred_ready         = !full;
    assign bus.train_valid        = train_q.valid;
    assign bus.train_taken        = train_q.taken;
    assign bus.train_mispredicted = train_q.mispredicted;
    assign bus.train_history      = train_q.history;
    assign bus.train_pc           = train_q.pc;
    assign bus.restore_valid      = restore_vld_q;
    assign bus.restore_history    = restore_hist_q;
    assign bus.occupancy          = occ;
    assign bus.overflow           = overflow_q;
    assign bus.underflow          = underflow_q;

endmodule

// File: doc/branch_train_tracker.md
Name: branch_train_tracker

Overview:
- Companion to the gshare predictor. Sits between the predictor's prediction outputs and its training inputs.
- Records every issued prediction (pc, history, predicted direction) in an in-order buffer of in-flight branches.
- On in-order branch resolution it produces the predictor's training interface: train_valid, train_taken, train_mispredicted, train_history and train_pc.
- On a mispredict it flushes all younger wrong-path entries and provides a repaired global history for the fetch side.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, minimum 2.
- HIST_W, 7, width of pc and history fields; matches the predictor's 128-entry PHT index.

Ports:
- clk  in  1  clock
- areset  in  1  reset
- pred_valid  in  1  prediction issued this cycle
- pred_pc  in  HIST_W  pc of predicted branch
- pred_taken  in  1  predicted direction
- pred_history  in  HIST_W  global history used for the prediction
- pred_ready  out  1  buffer can accept a prediction
- resolve_valid  in  1  oldest in-flight branch resolves this cycle
- resolve_taken  in  1  actual direction of that branch
- train_valid  out  1  training pulse to predictor
- train_taken  out  1  actual direction
- train_mispredicted  out  1  predicted direction differed from actual
- train_history  out  HIST_W  history stored with the entry
- train_pc  out  HIST_W  pc stored with the entry
- restore_valid  out  1  global history must be overwritten
- restore_history  out  HIST_W  repaired history
- occupancy  out  $clog2(DEPTH)+1  valid entries
- overflow  out  1  sticky: prediction dropped while full
- underflow  out  1  sticky: resolve arrived while empty

Behaviour:
- Interface: clock clk; reset areset, synchronous, active-high.
- Reset:
  - All outputs are 0 except pred_ready = 1.
  - Read and write pointers, occupancy and both sticky flags clear.
  - Reset asserted mid-operation discards all in-flight entries. No train pulse is produced for them.
- Storage: circular buffer of {pc, history, pred_taken}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - occupancy is tracked separately, so full and empty are unambiguous.
- pred_ready = (occupancy != DEPTH), decoded from registered state only.
- Push: on pred_valid && pred_ready, write the entry at wr_ptr, then increment wr_ptr.
  - pred_valid && !pred_ready sets overflow and drops the prediction.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Pop: on resolve_valid && occupancy != 0, read the entry at rd_ptr and compute mispred = (entry.pred_taken != resolve_taken).
  - resolve_valid with occupancy == 0 sets underflow and produces no output.
- Train output, registered, 1-cycle latency: in the cycle after a pop:
  - train_valid = 1 for exactly one cycle;
  - train_taken = resolve_taken;
  - train_mispredicted = mispred;
  - train_pc and train_history come from the entry.
  - When train_valid = 0, all train_* fields are 0.
- Non-mispredicted pop: rd_ptr increments.
  - A simultaneous push and pop leaves occupancy unchanged.
- Mispredicted pop (flush):
  - wr_ptr, rd_ptr and occupancy are all set to 0 next cycle.
  - A push in the same cycle is discarded, because it is wrong-path; overflow is not set by it.
  - restore_valid pulses in the same cycle as train_valid.
  - restore_history = {entry.history[HIST_W-2:0], resolve_taken}.
  - restore_valid = 0 and restore_history = 0 otherwise.
- Arithmetic: occupancy next = occupancy + push − pop. It never exceeds DEPTH and never goes below 0.
- The sticky flags clear only on reset.

Decomposition:
- Package branch_pkg:
  - HIST_W constant;
  - bp_entry_t packed struct {pc, history, pred_taken};
  - train_t packed struct for the train_* bundle.
- The predictor should import the same package.
- One natural sub-module: bp_entry_fifo, a parameterised circular buffer with push, pop, flush and occupancy.
- Resolution, mispredict detection and output registers stay in the top level.

Test Plan:
1. Reset, then push pc=0x05 hist=0x00 pred=1, then resolve taken=1 → one cycle later: train_valid=1, taken=1, mispredicted=0, pc=0x05, history=0x00, restore_valid=0, occupancy=0.
2. Push 3 entries (pred=0, 0, 1), then resolve the first with taken=1 → train_mispredicted=1, restore_valid=1, restore_history={hist0[5:0],1}, occupancy=0; the next resolve_valid sets underflow=1 with no train pulse.
3. Push 8 entries → pred_ready=0, occupancy=8; a 9th pred_valid sets overflow=1 and occupancy stays 8; pop one, push one repeatedly for 20 cycles → train order matches push order across pointer wrap.
4. occupancy=4, then same-cycle push and mispredicting resolve → push discarded, occupancy=0, overflow stays 0.
5. Push 2 entries, then assert areset for one cycle while resolve_valid=1 → no train_valid, occupancy=0, pred_ready=1, sticky flags 0.
6. At occupancy=3, same-cycle push and correct resolve → occupancy stays 3 and the pushed entry emerges fourth.
